// File: rtl/type_pkg.sv
`default_nettype none
// ============================================================================
// Module  : type_pkg
// Brief   : Shared types, opcode/funct3 encodings and access helpers for mem_access.
// Rev     : 1.0
// ============================================================================
package type_pkg;

    typedef logic [6:0]  opcode_t;
    typedef logic [31:0] data_t;

    localparam opcode_t    OP_LOAD  = 7'b0000011;
    localparam opcode_t    OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Legal funct3 for the opcode and natural alignment for the access size.
    function automatic logic access_legal(input opcode_t op, input logic [2:0] f3,
                                          input logic [1:0] a);
        logic f3_ok;
        logic aligned;
        f3_ok = 1'b0;
        if (op == OP_LOAD) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end else if (op == OP_STORE) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~a[0];
            default: aligned = (a == 2'b00);
        endcase
        return f3_ok && aligned;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store datum means every enabled lane already holds it.
    function automatic data_t store_lanes(input logic [2:0] f3, input data_t d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_align
// Brief   : Extracts the addressed byte/half/word from a read word and extends it.
// Rev     : 1.0
// ============================================================================
module mem_align
    import type_pkg::*;
(
    input  data_t       rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output data_t       result
);

    data_t w_shifted;

    always_comb begin
        w_shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    result = w_shifted;
            F3_BU:   result = {24'h0, w_shifted[7:0]};
            F3_HU:   result = {16'h0, w_shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module  : mem_access
// Brief   : Load/store stage: one data-cache access per start, with align/extend.
// Rev     : 1.0
// ============================================================================
module mem_access
    import type_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  opcode_t     opcode,
    input  logic [2:0]  funct3,
    input  data_t       alu_out,
    input  data_t       rs2_data,
    output logic        dcache_req,
    output logic        dcache_we,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_be,
    input  data_t       dcache_rdata,
    input  logic        dcache_ack,
    output data_t       dcache_out,
    output logic        done,
    output logic        busy,
    output logic        mem_err
);

    mem_state_t r_state;
    mem_state_t w_next;

    logic [2:0] r_funct3;
    data_t      r_addr;
    data_t      r_wdata;
    logic [3:0] r_be;
    logic       r_we;
    logic       r_is_load;
    logic       r_err;
    data_t      r_out;

    logic       w_is_mem;
    logic       w_legal;
    logic       w_accept;
    data_t      w_aligned;

    assign w_is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign w_legal  = access_legal(opcode, funct3, alu_out[1:0]);
    assign w_accept = (r_state == IDLE) && start;

    mem_align u_mem_align (
        .rdata  (dcache_rdata),
        .offset (r_addr[1:0]),
        .funct3 (r_funct3),
        .result (w_aligned)
    );

    always_comb begin
        w_next     = r_state;
        dcache_req = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        mem_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (w_is_mem && w_legal) ? REQ : DONE;
            end
            REQ: begin
                dcache_req = 1'b1;
                busy       = 1'b1;
                if (dcache_ack) w_next = DONE;
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                mem_err = r_err;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= 4'b0000;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_out     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3  <= funct3;
                r_addr    <= alu_out;
                r_wdata   <= store_lanes(funct3, rs2_data);
                r_be      <= byte_enables(funct3, alu_out[1:0]);
                r_we      <= (opcode == OP_STORE);
                r_is_load <= (opcode == OP_LOAD);
                r_err     <= w_is_mem && !w_legal;
                r_out     <= '0;
            end
            // Load result is latched on completion and held until the next start.
            if ((r_state == REQ) && dcache_ack && r_is_load) begin
                r_out <= w_aligned;
            end
        end
    end

    assign dcache_addr  = {r_addr[31:2], 2'b00};
    assign dcache_we    = r_we;
    assign dcache_be    = r_be;
    assign dcache_wdata = r_wdata;
    assign dcache_out   = r_out;

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port: clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  synchronous active-low reset.
REQ-004 Port: start  in  1  one-cycle pulse; the decode_execute outputs below are valid this cycle.
REQ-005 Port: opcode  in  opcode_t (7)  instruction opcode.
REQ-006 Port: funct3  in  3  access size and signedness.
REQ-007 Port: alu_out  in  data_t (32)  effective byte address.
REQ-008 Port: rs2_data  in  data_t (32)  store data, right-aligned.
REQ-009 Port: dcache_req / dcache_we  out  1 / 1  request valid / write.
REQ-010 Port: dcache_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-011 Port: dcache_wdata / dcache_be  out  32 / 4  lane-shifted store data / byte enables.
REQ-012 Port: dcache_rdata / dcache_ack  in  32 / 1  read word / request accepted and completed.
REQ-013 Port: dcache_out  out  data_t (32)  aligned, extended load result to writeback.
REQ-014 Port: done / busy / mem_err  out  1 / 1 / 1  completion pulse / access in progress / misaligned or illegal access.

Function
REQ-015 The FSM states SHALL be IDLE, REQ and DONE.
REQ-016 Transitions SHALL be:
  - IDLE + start + load/store with legal aligned access -> REQ.
  - IDLE + start + any other opcode, or an error -> DONE.
  - REQ + dcache_ack -> DONE.
  - DONE -> IDLE unconditionally.
REQ-017 On start in IDLE, the block SHALL register opcode, funct3, address and store data; later input changes SHALL NOT affect the access.
REQ-018 dcache_req SHALL be 1 exactly while in REQ; dcache_addr, dcache_we, dcache_wdata and dcache_be SHALL stay stable from REQ entry until ack.
REQ-019 A load is opcode 0000011 and SHALL drive dcache_we=0; a store is opcode 0100011 and SHALL drive dcache_we=1.
REQ-020 Byte enables SHALL be:
  - byte access: 4'b0001<<a[1:0];
  - half access: 4'b0011<<a[1:0];
  - word access: 4'b1111.
REQ-021 Store data SHALL be replicated into the enabled lanes: SB {4{b}}, SH {2{h}}, SW the full word.
REQ-022 On ack for a load, the block SHALL capture dcache_rdata, shift it right by 8*a[1:0], and extend it:
  - LB: sign-extend byte;
  - LH: sign-extend half;
  - LW: full word;
  - LBU: zero-extend byte;
  - LHU: zero-extend half.
REQ-023 dcache_out SHALL hold the captured load value from DONE until the next start; for stores and non-memory ops it SHALL be 0.
REQ-024 done SHALL be 1 for exactly one cycle, in DONE.
REQ-025 Latency for non-memory ops SHALL be 1 cycle (start at T, done at T+1); memory latency SHALL be 2 + ack-wait cycles.
REQ-026 busy SHALL be 1 in REQ and DONE; a start while busy SHALL be ignored.
REQ-027 A misaligned access (half with a[0]=1, word with a[1:0]!=0) or an illegal funct3 for load/store SHALL issue no cache request and SHALL go directly to DONE with mem_err=1 and dcache_out=0.
REQ-028 mem_err SHALL be valid only with done and 0 otherwise.
REQ-029 dcache_ack outside REQ SHALL be ignored.
REQ-030 start in the DONE cycle SHALL be ignored; upstream SHALL wait until busy=0.

Reset
REQ-031 With rst_n=0 at a clock edge, the state SHALL become IDLE.
REQ-032 At that same edge, dcache_req, dcache_we, dcache_be, done, busy and mem_err SHALL all become 0, and dcache_addr, dcache_wdata and dcache_out SHALL become 32'h0.
REQ-033 A reset during REQ SHALL drop dcache_req in the following cycle without producing done; a late ack SHALL be ignored.

Structure
REQ-034 OP_LOAD, OP_STORE, the funct3 size encodings and the mem_state_t enum SHALL live in type_pkg alongside opcode_t and data_t.
REQ-035 Load extraction and extension SHALL be a combinational sub-module named mem_align, instantiated once.

Verification
REQ-036 LW at 0x100, cache returns 0xDEADBEEF after 3 wait cycles -> dcache_req high for 4 cycles, be=1111, done at T+5, dcache_out=0xDEADBEEF.
REQ-037 LB at 0x103 with rdata 0x80123456 -> dcache_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 SH at 0x202 with rs2_data=0x0000ABCD -> dcache_we=1, addr=0x200, be=1100, wdata=0xABCDABCD, dcache_out=0.
REQ-039 LW at 0x101 -> no dcache_req, done at T+1 with mem_err=1; an ADD opcode -> done at T+1 with mem_err=0.
REQ-040 Reset asserted mid-REQ, then ack one cycle later -> no done, state IDLE, next LW completes normally.
